hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush controller for the RV32 5-stage pipeline. Handles the hazards that operand forwarding cannot resolve:
//  - load-use in ID
//  - taken branch/jump resolved in EX
//  - multi-cycle data-memory access in MEM
//  Drives pipeline-register enables/flushes, a memory-timeout watchdog and saturating performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem wait cycles before mem_err (>=2)
//  CNT_W        16  width of stall_cycles / flush_count
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  reset            in   1      synchronous, active-high
//  rs1_id, rs2_id   in   5      source regs of instruction in ID
//  use_rs1_id       in   1      ID instruction reads rs1
//  use_rs2_id       in   1      ID instruction reads rs2
//  memread_ex       in   1      EX instruction is a load
//  rd_ex            in   5      dest reg of EX instruction
//  branch_taken_ex  in   1      EX redirects PC this cycle
//  dmem_req         in   1      MEM stage has a load/store outstanding
//  dmem_ready       in   1      data memory completes the MEM access this cycle
//  pc_en            out  1      PC update enable
//  ifid_en          out  1      IF/ID register enable
//  ifid_flush       out  1      IF/ID becomes bubble (NOP)
//  idex_flush       out  1      ID/EX becomes bubble
//  exmem_en         out  1      EX/MEM register enable
//  memwb_bubble     out  1      MEM/WB receives bubble (regwrite=0)
//  mem_err          out  1      sticky watchdog error
//  stall_cycles     out  CNT_W  cycles with pc_en=0 since reset, saturating
//  flush_count      out  CNT_W  taken-branch flush events since reset, saturating
// BEHAVIOUR
//  - State register: RUN, MEM_WAIT, ERR. 6-bit wait_cnt. Control outputs are combinational from state + inputs; counters/mem_err registered.
//  - Reset (sync, priority over everything):
//    - next state RUN; wait_cnt=0; counters=0; mem_err=0.
//    - While reset=1, outputs: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, exmem_en=0, memwb_bubble=1.
//  - freeze = (dmem_req & ~dmem_ready) | state==ERR.
//  - Priority per cycle: freeze > branch flush > load-use > normal.
//    - freeze:   pc_en=0, ifid_en=0, exmem_en=0, memwb_bubble=1, ifid_flush=0, idex_flush=0; ID/EX holds (flush=0).
//    - branch:   branch_taken_ex & ~freeze -> pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_bubble=0. Load-use is ignored that cycle.
//    - load-use: lu = memread_ex & rd_ex!=0 & ((use_rs1_id & rd_ex==rs1_id) | (use_rs2_id & rd_ex==rs2_id)). If lu & ~freeze & ~branch: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, exmem_en=1, memwb_bubble=0. Exactly 1 bubble; forwarding covers the rest.
//    - normal:   pc_en=ifid_en=exmem_en=1, flushes=0, memwb_bubble=0.
//  - FSM:
//    - RUN -> MEM_WAIT when dmem_req & ~dmem_ready; wait_cnt<=1.
//    - MEM_WAIT:
//      - dmem_ready -> RUN, wait_cnt<=0. This cycle is not frozen; pipeline advances.
//      - dmem_req dropped -> RUN.
//      - Else wait_cnt++. When wait_cnt==MEM_TIMEOUT-1 and still not ready -> ERR.
//    - ERR: mem_err=1, pipeline frozen until reset. dmem_ready is ignored.
//  - Access latency: an access with ready on its first cycle adds 0 stall cycles; N wait cycles add N.
//  - stall_cycles: +1 each non-reset cycle with pc_en=0. flush_count: +1 each cycle the branch rule fires. Both saturate at all-ones, no wrap.
//  - Reset mid-MEM_WAIT or in ERR: state, counters and mem_err all return to their reset values on the next edge.
// TESTING
//  1 load x5 in EX, ID uses rs2=x5, use_rs2_id=1 -> one cycle pc_en=0, idex_flush=1; next cycle normal; stall_cycles=1.
//  2 load rd_ex=x0 vs rs1_id=0 -> no stall. Same regs with use_rs1_id=0 -> no stall.
//  3 branch_taken_ex=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1; flush_count=1; stall_cycles unchanged.
//  4 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles (memwb_bubble=1); branch_taken_ex=1 during freeze is ignored; 4th cycle normal.
//  5 dmem_req=1, ready never (MEM_TIMEOUT=16) -> mem_err=1 after 16 wait cycles, stays frozen; then reset=1 for 1 cycle -> mem_err=0, counters 0, normal.
//  6 CNT_W=4, hold load-use 20 cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32 pipeline: load-use, taken-branch and
// multi-cycle data-memory hazards, a dmem watchdog and saturating perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic             memread_ex,
    input  logic [4:0]       rd_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [5:0]       WAIT_END = 6'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [5:0] wait_cnt;
    logic       freeze;
    logic       lu;
    logic       branch_fire;

    // dmem handshake: dmem_req marks an outstanding MEM access; the access
    // completes on the cycle where dmem_req and dmem_ready are both high.
    // Any cycle with dmem_req high and dmem_ready low freezes the pipeline.
    assign freeze      = (dmem_req & ~dmem_ready) | (state == ERR);
    assign lu          = memread_ex & (rd_ex != 5'd0) &
                         ((use_rs1_id & (rd_ex == rs1_id)) |
                          (use_rs2_id & (rd_ex == rs2_id)));
    assign branch_fire = branch_taken_ex & ~freeze & ~reset;
    assign fsm_state   = state;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            // One bubble into EX; forwarding handles the load result afterwards.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 6'd0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (branch_fire && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;

            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 6'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready || !dmem_req) begin
                        state    <= RUN;
                        wait_cnt <= 6'd0;
                    end else if (wait_cnt == WAIT_END) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    localparam logic [5:0] C_RST = 6'b001101;
    localparam logic [5:0] C_FRZ = 6'b000001;
    localparam logic [5:0] C_BR  = 6'b111110;
    localparam logic [5:0] C_LU  = 6'b000110;
    localparam logic [5:0] C_NRM = 6'b110010;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        use_rs1_id, use_rs2_id, memread_ex;
    logic        branch_taken_ex, dmem_req, dmem_ready;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err;
    logic [15:0] stall_cycles, flush_count;
    logic [1:0]  fsm_state;
    logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, exmem_en4, memwb_bubble4, mem_err4;
    logic [3:0]  stall_cycles4, flush_count4;
    logic [1:0]  fsm_state4;

    // Entry: {chk4, stall4[3:0], ctrl[5:0], mem_err, stall[15:0], flush[15:0]}
    logic [43:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .memread_ex(memread_ex),
        .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .fsm_state(fsm_state)
    );

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .memread_ex(memread_ex),
        .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_en(exmem_en4),
        .memwb_bubble(memwb_bubble4), .mem_err(mem_err4), .stall_cycles(stall_cycles4),
        .flush_count(flush_count4), .fsm_state(fsm_state4)
    );

    task automatic drive(input logic r, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub, input logic mr,
                         input logic [4:0] rd, input logic br, input logic rq,
                         input logic rdy);
        reset = r; rs1_id = a; use_rs1_id = ua; rs2_id = b; use_rs2_id = ub;
        memread_ex = mr; rd_ex = rd; branch_taken_ex = br; dmem_req = rq; dmem_ready = rdy;
    endtask

    task automatic idle(input logic r);
        drive(r, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_cyc(input string nm, input logic [5:0] c, input logic err,
                              input logic [15:0] st, input logic [15:0] fl,
                              input logic chk4, input logic [3:0] st4);
        exp_q.push_back({chk4, st4, c, err, st, fl});
        name_q.push_back(nm);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [43:0] e;
            logic [38:0] got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble,
                   mem_err, stall_cycles, flush_count};
            checks++;
            if (got != e[38:0]) begin
                errors++;
                $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, want ctrl=%b err=%b stall=%0d flush=%0d",
                         nm, got[38:33], got[32], got[31:16], got[15:0],
                         e[38:33], e[32], e[31:16], e[15:0]);
            end
            if (e[43]) begin
                checks++;
                if (stall_cycles4 != e[42:39]) begin
                    errors++;
                    $display("FAIL %s_sat4: got stall4=%0d want %0d", nm, stall_cycles4, e[42:39]);
                end
            end
        end
    end

    initial begin
        idle(1'b1);
        next_cycle();
        idle(1'b1);
        expect_cyc("reset", C_RST, 1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
        next_cycle();

        // Load-use on rs2, then release
        drive(1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        expect_cyc("lu_rs2", C_LU, 1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
        next_cycle();
        idle(1'b0);
        expect_cyc("lu_after", C_NRM, 1'b0, 16'd1, 16'd0, 1'b0, 4'd0);
        next_cycle();

        // x0 destination and unused source never stall
        drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cyc("lu_x0", C_NRM, 1'b0, 16'd1, 16'd0, 1'b0, 4'd0);
        next_cycle();
        drive(1'b0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        expect_cyc("lu_unused", C_NRM, 1'b0, 16'd1, 16'd0, 1'b0, 4'd0);
        next_cycle();

        // Branch beats load-use
        drive(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        expect_cyc("branch_lu", C_BR, 1'b0, 16'd1, 16'd0, 1'b0, 4'd0);
        next_cycle();
        idle(1'b0);
        expect_cyc("branch_after", C_NRM, 1'b0, 16'd1, 16'd1, 1'b0, 4'd0);
        next_cycle();

        // Three wait cycles with a branch ignored during freeze
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            expect_cyc("mem_freeze", C_FRZ, 1'b0, 16'(1 + i), 16'd1, 1'b0, 4'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        expect_cyc("mem_done", C_NRM, 1'b0, 16'd4, 16'd1, 1'b0, 4'd0);
        next_cycle();
        idle(1'b0);
        expect_cyc("mem_after", C_NRM, 1'b0, 16'd4, 16'd1, 1'b0, 4'd0);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        expect_cyc("mem_zero_wait", C_NRM, 1'b0, 16'd4, 16'd1, 1'b0, 4'd0);
        next_cycle();

        // Watchdog: 16 wait cycles then sticky error, ready ignored
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_cyc("wdog_wait", C_FRZ, 1'b0, 16'(4 + i), 16'd1, 1'b0, 4'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect_cyc("err_frozen", C_FRZ, 1'b1, 16'd20, 16'd1, 1'b0, 4'd0);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_cyc("err_sticky", C_FRZ, 1'b1, 16'd21, 16'd1, 1'b0, 4'd0);
        next_cycle();
        idle(1'b1);
        expect_cyc("err_reset", C_RST, 1'b1, 16'd22, 16'd1, 1'b0, 4'd0);
        next_cycle();
        idle(1'b0);
        expect_cyc("post_reset", C_NRM, 1'b0, 16'd0, 16'd0, 1'b1, 4'd0);
        next_cycle();

        // Held load-use: 16-bit counter reaches 20, 4-bit one sticks at 15
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
            expect_cyc("lu_hold", C_LU, 1'b0, 16'(i), 16'd0, 1'b1, (i > 15) ? 4'd15 : 4'(i));
            next_cycle();
        end
        idle(1'b0);
        expect_cyc("sat_check", C_NRM, 1'b0, 16'd20, 16'd0, 1'b1, 4'd15);
        next_cycle();

        // Reset taken mid-MEM_WAIT
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cyc("wait_pre_reset", C_FRZ, 1'b0, 16'd20, 16'd0, 1'b1, 4'd15);
        next_cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cyc("wait_reset", C_RST, 1'b0, 16'd21, 16'd0, 1'b1, 4'd15);
        next_cycle();
        idle(1'b0);
        expect_cyc("wait_post_reset", C_NRM, 1'b0, 16'd0, 16'd0, 1'b1, 4'd0);
        next_cycle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) next_cycle();
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
